// File: rtl/conv_window_scheduler_if.sv
`default_nettype none
// conv_window_scheduler_if: frame-memory read port, accelerator FIFO/result port and result stream.
// master = scheduler side, slave = memory/accelerator/downstream side.
interface conv_window_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              acc_start;
  logic              acc_wr;
  logic [DATA_W-1:0] acc_din;
  logic              acc_full;
  logic              acc_ready;
  logic [DATA_W-1:0] acc_sum;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd, acc_start, acc_wr, acc_din,
    output out_data, out_row, out_col, out_valid,
    input  mem_rdata, acc_full, acc_ready, acc_sum, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, acc_start, acc_wr, acc_din,
    input  out_data, out_row, out_col, out_valid,
    output mem_rdata, acc_full, acc_ready, acc_sum, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// conv_window_scheduler: walks every 3x3 window of a frame, feeds its 9 pixels to the
// convolution accelerator FIFO and streams each result out with its coordinates.
module conv_window_scheduler #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  conv_window_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_OUTPUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        TAPS     = 4'd9;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row, col, win_row, win_col;
  logic [1:0]        kr, kc;
  logic [3:0]        rd_cnt, wr_cnt;
  logic              pend, skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_row, res_col;
  logic              fetching, rd_en, wr_mem, wr_skid, wr_any, last_pos;

  // A read is only launched when its data is guaranteed a home: the FIFO can take it
  // next cycle or, failing that, the (empty) skid register can.
  assign fetching = (state == S_FETCH);
  assign rd_en    = fetching && !bus.acc_full && !skid_valid && (rd_cnt != TAPS);
  assign wr_mem   = fetching && pend && !bus.acc_full;
  assign wr_skid  = fetching && skid_valid && !bus.acc_full;
  assign wr_any   = wr_mem || wr_skid;
  assign win_row  = row + ADDR_W'(kr);
  assign win_col  = col + ADDR_W'(kc);
  assign last_pos = (row == LAST_ROW) && (col == LAST_COL);

  assign bus.mem_rd   = rd_en;
  assign bus.mem_addr = rd_en ? (BASE + win_row * STRIDE + win_col) : '0;
  assign bus.acc_wr   = wr_any;
  assign bus.acc_din  = wr_skid ? skid_data : (wr_mem ? bus.mem_rdata : '0);
  assign bus.out_data = res_data;
  assign bus.out_row  = res_row;
  assign bus.out_col  = res_col;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.acc_start = 1'b0;
    bus.out_valid = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_START;
      S_START: begin
        bus.acc_start = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_FETCH:  if (wr_any && (wr_cnt == 4'd8)) state_nxt = S_WAIT;
      S_WAIT:   if (bus.acc_ready) state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = last_pos ? S_DONE : S_START;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      kr         <= '0;
      kc         <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      pend       <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      res_data   <= '0;
      res_row    <= '0;
      res_col    <= '0;
    end else begin
      pend <= rd_en;
      if (state == S_IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (state == S_START) begin
        kr     <= '0;
        kc     <= '0;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (kc == 2'd2) begin
          kc <= '0;
          kr <= kr + 2'd1;
        end else begin
          kc <= kc + 2'd1;
        end
      end
      if (wr_any) wr_cnt <= wr_cnt + 4'd1;
      // Returning data that the FIFO cannot take this cycle parks in the skid register.
      if (fetching && pend && bus.acc_full) begin
        skid_valid <= 1'b1;
        skid_data  <= bus.mem_rdata;
      end else if (wr_skid) begin
        skid_valid <= 1'b0;
      end
      if (state == S_WAIT && bus.acc_ready) begin
        res_data <= bus.acc_sum;
        res_row  <= row;
        res_col  <= col;
      end
      if (state == S_OUTPUT && bus.out_ready) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
